adcalign: RTL and testbench
===========================

# adcalign

Automatic link-training controller for an ADC receiver with a parametrised lane count and deserializer width. It sits beside the per-line ISERDES/IODELAY receivers in the CLK domain. It sweeps the shared IODELAY tap range and measures data stability on every line at each tap. It then centres each line in its widest stable eye and coherently bitslips all lines until the frame word matches the expected pattern. It replaces manual delay and bitslip tuning over Wishbone with a single START pulse and a DONE/FAIL result.

## Interface
- NLINES, 8: data bit lines; the frame is handled as an extra line, index NLINES.
- DW, 6: deserialized word width per line.
- NTAP, 64: tap positions swept (0..NTAP-1).
- DWELL, 256: cycles of stability measurement per tap.
- GAP, 4: settle cycles after every DRST/DINC/BS pulse.
- MINEYE, 4: minimum acceptable eye width, in taps.
- FRPAT, 6'b111000: expected frame word, DW bits wide.
- CLK  in  1  deserialized-data clock; the only clock.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  single-cycle request; ignored while BUSY.
- DATA  in  NLINES*DW  deserialized line words; line i is DATA[DW*i+DW-1:DW*i].
- FRAME  in  DW  deserialized frame word.
- DRST  out  1  IODELAY reset pulse; returns all taps to 0.
- DINC  out  NLINES+1  per-line IODELAY increment pulses; bit NLINES is the frame.
- BS  out  1  coherent bitslip pulse to all lines and the frame.
- BUSY  out  1  training in progress.
- DONE  out  1  sticky success; cleared by START or RST.
- FAIL  out  1  sticky failure; cleared by START or RST.
- FAILCODE  out  2  0 none, 1 eye too narrow, 2 no frame lock.
- SEL  in  clog2(NLINES+1)  status line select.
- EYE_START  out  clog2(NTAP)  best eye start tap for line SEL.
- EYE_LEN  out  clog2(NTAP+1)  best eye width for line SEL.

## Operation
- States: IDLE, DRST1, SETTLE, MEAS, STEP, EVAL, DRST2, PLACE, ALIGN, BSWAIT, DONE, FAIL.
- IDLE: on START, clear DONE/FAIL/FAILCODE and all eye trackers, set BUSY, and enter DRST1.
- DRST1: pulse DRST for one cycle, then enter SETTLE with tap=0.
- SETTLE: wait GAP cycles, then enter MEAS.
- MEAS: run for DWELL cycles. Line i is unstable at this tap if its word differs from its previous-cycle word on any of cycles 2..DWELL.
- STEP: each tracker extends its current run if the tap was stable; otherwise it closes the run.
  - A closed run replaces the best run only if it is strictly longer, so the earlier of two equal runs wins.
  - If tap<NTAP-1: pulse DINC on all lines, increment tap, and return to SETTLE.
  - Otherwise: close any open run (a run reaching the last tap is valid) and enter EVAL.
- EVAL: if any line has best length < MINEYE, enter FAIL with code 1. Otherwise compute center[i] = best_start[i] + (best_len[i]>>1) and enter DRST2.
- DRST2: pulse DRST, wait GAP cycles, set k=0, and enter PLACE.
- PLACE: in each round, pulse DINC[i] for every line with k<center[i], increment k, and wait GAP cycles. Enter ALIGN when k equals max(center).
- ALIGN: compare FRAME with FRPAT.
  - Match: enter DONE.
  - No match, with fewer than DW bitslips issued: pulse BS, wait GAP cycles (BSWAIT), and recheck.
  - No match after DW bitslips: enter FAIL with code 2.
- DONE/FAIL: set the sticky flag, drop BUSY, and return to IDLE.
- EYE_* are valid after EVAL and held until the next START.
- RST mid-operation returns to IDLE with all outputs 0; IODELAY taps are then unknown, and the next START always begins with DRST1.

## Timing
- Reset values: DRST, DINC, BS, BUSY, DONE, FAIL, FAILCODE, EYE_START, EYE_LEN are all 0.
- All outputs are registered. DRST, DINC, and BS are exactly one cycle wide and separated by at least GAP idle cycles.
- START accepted in IDLE: BUSY rises the next cycle, and DRST rises one cycle after BUSY.
- Sweep length: NTAP*(GAP+DWELL+1) cycles plus overhead.
- FRAME/DATA are sampled registered; the match in ALIGN is evaluated on the cycle after BSWAIT ends.
- START on the same cycle as RST: RST wins.

## Structure
- Package adcalign_pkg holds:
  - the state enum;
  - tap and length width functions (clog2(NTAP), clog2(NTAP+1));
  - the FAILCODE constants.
- Sub-module adceye, instantiated NLINES+1 times. It contains the per-line instability detector, run counter, and best_start/best_len registers, with ports clear, meas, step, last, data[DW], start_o, len_o.

## Test plan
- Clean sweep: the bench model makes line 3 stable at taps 20..35 and all other lines stable at 10..50; frame aligned. Required: EYE_START=20 and EYE_LEN=16 for SEL=3; line 3 gets 28 DINC pulses in PLACE, the others 30; DONE=1; zero BS pulses.
- Equal eyes: line 0 stable at taps 5..9 and 40..44. Required: EYE_START=5, EYE_LEN=5.
- Narrow eye: line 7 stable only at taps 30..32 with MINEYE=4. Required: FAIL=1, FAILCODE=1, no DRST2 pulse.
- Bitslip: frame arrives rotated so that two slips give 111000. Required: exactly 2 BS pulses, each followed by at least GAP idle cycles, then DONE=1.
- Frame never matches (constant 101010). Required: 6 BS pulses, then FAIL=1, FAILCODE=2.
- RST asserted mid-MEAS, then START. Required: all outputs 0 during reset; DRST is the first pulse after the new START; a START issued while BUSY is ignored.

Source files
------------

// File: rtl/adcalign_pkg.sv
// Shared types and helpers for the ADC link-training controller.
package adcalign_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_DRST1,
      S_SETTLE,
      S_MEAS,
      S_STEP,
      S_EVAL,
      S_DRST2,
      S_PLACE,
      S_ALIGN,
      S_BSWAIT,
      S_DONE,
      S_FAIL
   } state_t;

   localparam logic [1:0] FC_NONE = 2'd0;
   localparam logic [1:0] FC_EYE  = 2'd1;
   localparam logic [1:0] FC_LOCK = 2'd2;

   function automatic int tap_w(input int ntap);
      return (ntap > 1) ? $clog2(ntap) : 1;
   endfunction

   function automatic int len_w(input int ntap);
      return $clog2(ntap + 1);
   endfunction

endpackage

// File: rtl/adcalign_eye.sv
// Per-line eye tracker: flags instability during a dwell and keeps the
// longest stable tap run seen across the sweep.
module adceye
   import adcalign_pkg::*;
#(
   parameter int DW   = 6,
   parameter int NTAP = 64,
   localparam int TW  = tap_w(NTAP),
   localparam int LW  = len_w(NTAP)
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          clear,
   input  logic          meas,
   input  logic          step,
   input  logic          last,
   input  logic [DW-1:0] data,
   output logic [TW-1:0] start_o,
   output logic [LW-1:0] len_o
);

   logic [DW-1:0] prev_reg;
   logic          unstable_reg;
   logic [TW-1:0] tap_reg;
   logic [TW-1:0] run_start_reg;
   logic [LW-1:0] run_len_reg;
   logic [TW-1:0] best_start_reg;
   logic [LW-1:0] best_len_reg;

   logic          stable;
   logic          closing;
   logic [TW-1:0] ext_start;
   logic [LW-1:0] ext_len;

   // ext_* is the run including this tap when stable; it doubles as the
   // closed run when the tap is unstable, since then it equals the open run.
   always_comb begin
      stable    = ~unstable_reg;
      ext_start = (run_len_reg == '0) ? tap_reg : run_start_reg;
      ext_len   = stable ? run_len_reg + LW'(1) : run_len_reg;
      closing   = ~stable | last;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         prev_reg       <= '0;
         unstable_reg   <= 1'b0;
         tap_reg        <= '0;
         run_start_reg  <= '0;
         run_len_reg    <= '0;
         best_start_reg <= '0;
         best_len_reg   <= '0;
      end else begin
         prev_reg <= data;
         if (clear) begin
            unstable_reg   <= 1'b0;
            tap_reg        <= '0;
            run_start_reg  <= '0;
            run_len_reg    <= '0;
            best_start_reg <= '0;
            best_len_reg   <= '0;
         end else if (step) begin
            unstable_reg <= 1'b0;
            tap_reg      <= tap_reg + TW'(1);
            if (closing) begin
               run_len_reg <= '0;
               // strictly longer only, so the earliest of equal eyes is kept
               if (ext_len > best_len_reg) begin
                  best_start_reg <= ext_start;
                  best_len_reg   <= ext_len;
               end
            end else begin
               run_start_reg <= ext_start;
               run_len_reg   <= ext_len;
            end
         end else if (meas && (data != prev_reg)) begin
            unstable_reg <= 1'b1;
         end
      end
   end

   assign start_o = best_start_reg;
   assign len_o   = best_len_reg;

endmodule

// File: rtl/adcalign.sv
// Link-training controller: sweeps IODELAY taps, centres every line in its
// widest eye, then bitslips all lines until the frame word locks.
module adcalign
   import adcalign_pkg::*;
#(
   parameter int          NLINES = 8,
   parameter int          DW     = 6,
   parameter int          NTAP   = 64,
   parameter int          DWELL  = 256,
   parameter int          GAP    = 4,
   parameter int          MINEYE = 4,
   parameter logic [DW-1:0] FRPAT = 6'b111000,
   localparam int NL = NLINES + 1,
   localparam int TW = tap_w(NTAP),
   localparam int LW = len_w(NTAP),
   localparam int SW = (NL > 1) ? $clog2(NL) : 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   input  logic [NLINES*DW-1:0] DATA,
   input  logic [DW-1:0]        FRAME,
   output logic                 DRST,
   output logic [NLINES:0]      DINC,
   output logic                 BS,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 FAIL,
   output logic [1:0]           FAILCODE,
   input  logic [SW-1:0]        SEL,
   output logic [TW-1:0]        EYE_START,
   output logic [LW-1:0]        EYE_LEN
);

   localparam int CMAX = (DWELL > GAP) ? DWELL : GAP;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int BW   = $clog2(DW + 1);

   state_t          state_reg, state_next;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [TW-1:0]   tap_reg, tap_next;
   logic [LW-1:0]   k_reg, k_next;
   logic [BW-1:0]   bs_cnt_reg, bs_cnt_next;
   logic [LW-1:0]   center_reg [NL];
   logic [LW-1:0]   cmax_reg;
   logic            drst_reg, drst_next;
   logic [NL-1:0]   dinc_reg, dinc_next;
   logic            bs_reg, bs_next;
   logic            busy_reg, busy_next;
   logic            done_reg, done_next;
   logic            fail_reg, fail_next;
   logic [1:0]      fc_reg, fc_next;
   logic            eye_valid_reg, eye_valid_next;
   logic [TW-1:0]   eye_start_reg;
   logic [LW-1:0]   eye_len_reg;
   logic [NL*DW-1:0] data_reg;

   logic            clear_eye, meas_en, step_en, last_tap, load_center;
   logic [TW-1:0]   eye_start_w [NL];
   logic [LW-1:0]   eye_len_w [NL];
   logic [LW-1:0]   center_w [NL];
   logic [NL-1:0]   narrow_w;
   logic [LW-1:0]   cmax_w;
   logic [DW-1:0]   frame_w;

   assign frame_w  = data_reg[NL*DW-1 -: DW];
   assign last_tap = (tap_reg == TW'(NTAP - 1));

   genvar gi;
   generate
      for (gi = 0; gi < NL; gi++) begin : g_eye
         adceye #(.DW(DW), .NTAP(NTAP)) u_eye (
            .CLK     (CLK),
            .RST     (RST),
            .clear   (clear_eye),
            .meas    (meas_en),
            .step    (step_en),
            .last    (last_tap),
            .data    (data_reg[DW*gi +: DW]),
            .start_o (eye_start_w[gi]),
            .len_o   (eye_len_w[gi])
         );
         assign center_w[gi] = LW'(eye_start_w[gi]) + (eye_len_w[gi] >> 1);
         assign narrow_w[gi] = (eye_len_w[gi] < LW'(MINEYE));
      end
   endgenerate

   always_comb begin
      cmax_w = '0;
      for (int i = 0; i < NL; i++) begin
         if (center_w[i] > cmax_w) cmax_w = center_w[i];
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      tap_next       = tap_reg;
      k_next         = k_reg;
      bs_cnt_next    = bs_cnt_reg;
      drst_next      = 1'b0;
      dinc_next      = '0;
      bs_next        = 1'b0;
      busy_next      = busy_reg;
      done_next      = done_reg;
      fail_next      = fail_reg;
      fc_next        = fc_reg;
      eye_valid_next = eye_valid_reg;
      clear_eye      = 1'b0;
      meas_en        = 1'b0;
      step_en        = 1'b0;
      load_center    = 1'b0;
      case (state_reg)
         S_IDLE: begin
            if (START) begin
               clear_eye      = 1'b1;
               done_next      = 1'b0;
               fail_next      = 1'b0;
               fc_next        = FC_NONE;
               eye_valid_next = 1'b0;
               busy_next      = 1'b1;
               state_next     = S_DRST1;
            end
         end
         S_DRST1: begin
            drst_next  = 1'b1;
            tap_next   = '0;
            cnt_next   = '0;
            state_next = S_SETTLE;
         end
         S_SETTLE: begin
            if (cnt_reg == CW'(GAP - 1)) begin
               cnt_next   = '0;
               state_next = S_MEAS;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         S_MEAS: begin
            // first dwell cycle has no valid previous word at this tap
            meas_en = (cnt_reg != '0);
            if (cnt_reg == CW'(DWELL - 1)) begin
               cnt_next   = '0;
               state_next = S_STEP;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         S_STEP: begin
            step_en = 1'b1;
            if (!last_tap) begin
               dinc_next  = '1;
               tap_next   = tap_reg + TW'(1);
               state_next = S_SETTLE;
            end else begin
               state_next = S_EVAL;
            end
         end
         S_EVAL: begin
            eye_valid_next = 1'b1;
            cnt_next       = '0;
            if (|narrow_w) begin
               fc_next    = FC_EYE;
               state_next = S_FAIL;
            end else begin
               load_center = 1'b1;
               state_next  = S_DRST2;
            end
         end
         S_DRST2: begin
            drst_next = (cnt_reg == '0);
            if (cnt_reg == CW'(GAP)) begin
               cnt_next   = '0;
               k_next     = '0;
               state_next = S_PLACE;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         S_PLACE: begin
            // cnt 0 issues a round of increments, cnt 1..GAP lets taps settle
            if (cnt_reg == '0) begin
               if (k_reg == cmax_reg) begin
                  bs_cnt_next = '0;
                  state_next  = S_ALIGN;
               end else begin
                  for (int i = 0; i < NL; i++) begin
                     dinc_next[i] = (k_reg < center_reg[i]);
                  end
                  k_next   = k_reg + LW'(1);
                  cnt_next = CW'(1);
               end
            end else if (cnt_reg == CW'(GAP)) begin
               cnt_next = '0;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         S_ALIGN: begin
            if (frame_w == FRPAT) begin
               state_next = S_DONE;
            end else if (bs_cnt_reg < BW'(DW)) begin
               bs_next     = 1'b1;
               bs_cnt_next = bs_cnt_reg + BW'(1);
               cnt_next    = '0;
               state_next  = S_BSWAIT;
            end else begin
               fc_next    = FC_LOCK;
               state_next = S_FAIL;
            end
         end
         S_BSWAIT: begin
            if (cnt_reg == CW'(GAP - 1)) begin
               cnt_next   = '0;
               state_next = S_ALIGN;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         S_DONE: begin
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = S_IDLE;
         end
         S_FAIL: begin
            fail_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= '0;
         tap_reg       <= '0;
         k_reg         <= '0;
         bs_cnt_reg    <= '0;
         cmax_reg      <= '0;
         drst_reg      <= 1'b0;
         dinc_reg      <= '0;
         bs_reg        <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         fail_reg      <= 1'b0;
         fc_reg        <= FC_NONE;
         eye_valid_reg <= 1'b0;
         eye_start_reg <= '0;
         eye_len_reg   <= '0;
         data_reg      <= '0;
         for (int i = 0; i < NL; i++) center_reg[i] <= '0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         tap_reg       <= tap_next;
         k_reg         <= k_next;
         bs_cnt_reg    <= bs_cnt_next;
         drst_reg      <= drst_next;
         dinc_reg      <= dinc_next;
         bs_reg        <= bs_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         fail_reg      <= fail_next;
         fc_reg        <= fc_next;
         eye_valid_reg <= eye_valid_next;
         data_reg      <= {FRAME, DATA};
         if (load_center) begin
            cmax_reg <= cmax_w;
            for (int i = 0; i < NL; i++) center_reg[i] <= center_w[i];
         end
         if (eye_valid_reg && (SEL < SW'(NL))) begin
            eye_start_reg <= eye_start_w[SEL];
            eye_len_reg   <= eye_len_w[SEL];
         end else begin
            eye_start_reg <= '0;
            eye_len_reg   <= '0;
         end
      end
   end

   assign DRST      = drst_reg;
   assign DINC      = dinc_reg;
   assign BS        = bs_reg;
   assign BUSY      = busy_reg;
   assign DONE      = done_reg;
   assign FAIL      = fail_reg;
   assign FAILCODE  = fc_reg;
   assign EYE_START = eye_start_reg;
   assign EYE_LEN   = eye_len_reg;

endmodule

// File: tb/tb_adcalign.sv
// Directed bench for adcalign with a behavioural IODELAY/bitslip model of
// per-line stability windows.
module tb_adcalign;

   localparam int NLINES = 8;
   localparam int DW     = 6;
   localparam int NTAP   = 64;
   localparam int DWELL  = 16;
   localparam int GAP    = 4;
   localparam int MINEYE = 4;
   localparam int NL     = NLINES + 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [NLINES*DW-1:0] data;
   logic [DW-1:0]        frame;
   logic                 drst;
   logic [NLINES:0]      dinc;
   logic                 bs;
   logic                 busy;
   logic                 done;
   logic                 fail;
   logic [1:0]           failcode;
   logic [3:0]           sel;
   logic [5:0]           eye_start;
   logic [6:0]           eye_len;

   always #5 clk = ~clk;

   adcalign #(
      .NLINES(NLINES), .DW(DW), .NTAP(NTAP), .DWELL(DWELL),
      .GAP(GAP), .MINEYE(MINEYE), .FRPAT(6'b111000)
   ) dut (
      .CLK(clk), .RST(rst), .START(start), .DATA(data), .FRAME(frame),
      .DRST(drst), .DINC(dinc), .BS(bs), .BUSY(busy), .DONE(done),
      .FAIL(fail), .FAILCODE(failcode), .SEL(sel),
      .EYE_START(eye_start), .EYE_LEN(eye_len)
   );

   int total = 0;
   int bad   = 0;

   int lo [NL];
   int hi [NL];
   int lo2 [NL];
   int hi2 [NL];
   logic [DW-1:0] fbase;

   int tap [NL] = '{default: 0};
   int dinc_n [NL] = '{default: 0};
   int drst_n = 0;
   int bs_n = 0;
   int cyc = 0;
   int gap_viol = 0;
   int last_pulse = -100;

   int dinc_base [NL];
   int drst_base, bs_base, gap_base;

   function automatic logic [DW-1:0] rotl(input logic [DW-1:0] v, input int n);
      logic [DW-1:0] r = v;
      for (int j = 0; j < n; j++) r = {r[DW-2:0], r[DW-1]};
      return r;
   endfunction

   // IODELAY/bitslip model: pulses observed this cycle take effect before
   // the next DUT sampling edge.
   always @(negedge clk) begin
      logic pulse;
      cyc = cyc + 1;
      pulse = drst | bs | (|dinc);
      if (rst) begin
         last_pulse = -100;
      end else if (pulse) begin
         if (cyc - last_pulse <= GAP) gap_viol = gap_viol + 1;
         last_pulse = cyc;
      end
      if (drst) begin
         drst_n = drst_n + 1;
         for (int i = 0; i < NL; i++) tap[i] = 0;
      end
      for (int i = 0; i < NL; i++) begin
         if (dinc[i]) begin
            tap[i]    = tap[i] + 1;
            dinc_n[i] = dinc_n[i] + 1;
         end
      end
      if (bs) bs_n = bs_n + 1;
      for (int i = 0; i < NL; i++) begin
         logic [DW-1:0] w;
         logic stb;
         stb = (tap[i] >= lo[i] && tap[i] <= hi[i]) ||
               (tap[i] >= lo2[i] && tap[i] <= hi2[i]);
         if (!stb)            w = cyc[0] ? 6'h15 : 6'h2A;
         else if (i == NLINES) w = rotl(fbase, (bs_n - bs_base) % DW);
         else                  w = DW'(i + 1);
         if (i < NLINES) data[DW*i +: DW] = w;
         else            frame = w;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic snap();
      for (int i = 0; i < NL; i++) dinc_base[i] = dinc_n[i];
      drst_base = drst_n;
      bs_base   = bs_n;
      gap_base  = gap_viol;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_end(input string name);
      logic ok = 1'b0;
      for (int n = 0; n < 5000; n++) begin
         if (done || fail) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({name, "_timeout"}, {31'd0, ok}, 32'd1);
      $display("run %s: done=%0b fail=%0b code=%0d bs=%0d drst=%0d", name,
               done, fail, failcode, bs_n - bs_base, drst_n - drst_base);
   endtask

   task automatic look(input logic [3:0] s);
      sel = s;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      sel = 4'd0;
      fbase = 6'b111000;
      for (int i = 0; i < NL; i++) begin
         lo[i] = 10; hi[i] = 50; lo2[i] = -1; hi2[i] = -1;
      end
      bs_base = 0;
      repeat (3) @(negedge clk);
      chk("reset_outs", {drst, dinc, bs, busy, done, fail, failcode, eye_start, eye_len}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // clean sweep, frame already aligned
      lo[3] = 20; hi[3] = 35; sel = 4'd3;
      snap();
      pulse_start();
      chk("clean_busy", {31'd0, busy}, 32'd1);
      wait_end("clean");
      chk("clean_done", {29'd0, done, fail, busy}, 32'b100);
      chk("clean_code", {30'd0, failcode}, 32'd0);
      look(4'd3);
      chk("clean_l3_start", {26'd0, eye_start}, 32'd20);
      chk("clean_l3_len", {25'd0, eye_len}, 32'd16);
      chk("clean_l3_dinc", dinc_n[3] - dinc_base[3], 32'd91);
      chk("clean_l0_dinc", dinc_n[0] - dinc_base[0], 32'd93);
      chk("clean_fr_dinc", dinc_n[8] - dinc_base[8], 32'd93);
      chk("clean_bs", bs_n - bs_base, 32'd0);
      chk("clean_drst", drst_n - drst_base, 32'd2);
      chk("clean_gap", gap_viol - gap_base, 32'd0);
      look(4'd0);
      chk("clean_l0_start", {26'd0, eye_start}, 32'd10);
      chk("clean_l0_len", {25'd0, eye_len}, 32'd41);
      look(4'd12);
      chk("clean_sel_oor", {19'd0, eye_start, eye_len}, 32'd0);

      // two equal eyes on line 0, the earlier must win
      lo[3] = 10; hi[3] = 50;
      lo[0] = 5; hi[0] = 9; lo2[0] = 40; hi2[0] = 44;
      sel = 4'd0;
      snap();
      pulse_start();
      wait_end("equal");
      chk("equal_done", {30'd0, done, fail}, 32'b10);
      look(4'd0);
      chk("equal_start", {26'd0, eye_start}, 32'd5);
      chk("equal_len", {25'd0, eye_len}, 32'd5);
      chk("equal_l0_dinc", dinc_n[0] - dinc_base[0], 32'd70);

      // line 7 eye narrower than MINEYE
      lo[0] = 10; hi[0] = 50; lo2[0] = -1; hi2[0] = -1;
      lo[7] = 30; hi[7] = 32;
      snap();
      pulse_start();
      wait_end("narrow");
      chk("narrow_flags", {30'd0, done, fail}, 32'b01);
      chk("narrow_code", {30'd0, failcode}, 32'd1);
      chk("narrow_drst", drst_n - drst_base, 32'd1);
      chk("narrow_dinc", dinc_n[0] - dinc_base[0], 32'd63);
      look(4'd7);
      chk("narrow_start", {26'd0, eye_start}, 32'd30);
      chk("narrow_len", {25'd0, eye_len}, 32'd3);

      // frame needs two bitslips
      lo[7] = 10; hi[7] = 50;
      fbase = 6'b001110;
      snap();
      pulse_start();
      wait_end("slip2");
      chk("slip2_flags", {29'd0, done, fail, failcode}, 32'b1000);
      chk("slip2_bs", bs_n - bs_base, 32'd2);
      chk("slip2_gap", gap_viol - gap_base, 32'd0);

      // frame never matches
      fbase = 6'b101010;
      snap();
      pulse_start();
      wait_end("nolock");
      chk("nolock_flags", {30'd0, done, fail}, 32'b01);
      chk("nolock_code", {30'd0, failcode}, 32'd2);
      chk("nolock_bs", bs_n - bs_base, 32'd6);
      chk("nolock_gap", gap_viol - gap_base, 32'd0);

      // reset mid-sweep, restart, and a START while busy
      fbase = 6'b111000;
      snap();
      pulse_start();
      repeat (300) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_outs", {drst, dinc, bs, busy, done, fail, failcode, eye_start, eye_len}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      snap();
      pulse_start();
      chk("restart_busy", {30'd0, busy, drst}, 32'b10);
      @(negedge clk);
      chk("restart_drst", {31'd0, drst}, 32'd1);
      chk("restart_first", dinc_n[0] - dinc_base[0] + bs_n - bs_base, 32'd0);
      repeat (40) @(negedge clk);
      pulse_start();
      wait_end("restart");
      chk("restart_done", {30'd0, done, fail}, 32'b10);
      chk("restart_drst_n", drst_n - drst_base, 32'd2);
      chk("restart_dinc", dinc_n[0] - dinc_base[0], 32'd93);
      look(4'd0);
      chk("restart_len", {25'd0, eye_len}, 32'd41);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
